// File: rtl/dense_4_argmax_out.sv
// Streaming argmax over N_CLASSES signed logits per frame: emits class index, max logit and top-1/top-2 margin.
// Optional: define DENSE_4_ARGMAX_SATURATE_MARGIN_EN to clamp out_margin to [0, 2^(W-1)-1].
module dense_4_argmax_out #(
    parameter int W         = 13,
    parameter int NFRAC     = 6,
    parameter int N_CLASSES = 5,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_class,
    output logic [W-1:0]     out_max,
    output logic [W:0]       out_margin,
    output logic             out_err
);
    typedef enum logic {ACCUM, OUTPUT} state_t;

    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_CLASSES - 1);
`ifdef DENSE_4_ARGMAX_SATURATE_MARGIN_EN
    localparam logic signed [W:0]   MARGIN_CLAMP = {2'b00, {(W-1){1'b1}}};
`endif

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    cls_q, cls_d;
    logic signed [W-1:0] max_q, max_d;
    logic signed [W-1:0] sec_q, sec_d;
    logic signed [W-1:0] din;
    logic signed [W:0]   margin_raw;
    logic [W:0]          margin_d;
    logic                beat_fire, at_last_idx, term, err_d;

    logic                in_ready_q, out_valid_q, out_err_q;
    logic [IDX_W-1:0]    out_class_q;
    logic [W-1:0]        out_max_q;
    logic [W:0]          out_margin_q;

    // Running top-2 including the beat currently on the bus, so the terminating
    // beat's result can be registered straight into the output stage.
    always_comb begin
        din   = $signed(in_data);
        max_d = max_q;
        sec_d = sec_q;
        cls_d = cls_q;
        if (din > max_q) begin
            sec_d = max_q;
            max_d = din;
            cls_d = idx_q;
        end else if (din > sec_q) begin
            sec_d = din;
        end
        margin_raw = {max_d[W-1], max_d} - {sec_d[W-1], sec_d};
`ifdef DENSE_4_ARGMAX_SATURATE_MARGIN_EN
        if (margin_raw > MARGIN_CLAMP) margin_d = MARGIN_CLAMP;
        else                           margin_d = margin_raw;
`else
        margin_d = margin_raw;
`endif
    end

    assign beat_fire   = in_valid & in_ready_q;
    assign at_last_idx = (idx_q == LAST_IDX);
    assign term        = at_last_idx | in_last;
    assign err_d       = in_last ^ at_last_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ACCUM;
            idx_q        <= '0;
            cls_q        <= '0;
            max_q        <= MOST_NEG;
            sec_q        <= MOST_NEG;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_max_q    <= '0;
            out_margin_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (beat_fire) begin
                        max_q <= max_d;
                        sec_q <= sec_d;
                        cls_q <= cls_d;
                        if (term) begin
                            state_q      <= OUTPUT;
                            idx_q        <= '0;
                            in_ready_q   <= 1'b0;
                            out_valid_q  <= 1'b1;
                            out_class_q  <= cls_d;
                            out_max_q    <= max_d;
                            out_margin_q <= margin_d;
                            out_err_q    <= err_d;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state_q     <= ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        cls_q       <= '0;
                        max_q       <= MOST_NEG;
                        sec_q       <= MOST_NEG;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_class  = out_class_q;
    assign out_max    = out_max_q;
    assign out_margin = out_margin_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_dense_4_argmax_out.sv
// Randomised + directed bench for dense_4_argmax_out against a queue-based argmax model.
module tb_dense_4_argmax_out;
    localparam int W = 13;
    localparam int N = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_class;
    logic [W-1:0]  out_max;
    logic [W:0]    out_margin;
    logic          out_err;

    dense_4_argmax_out #(.W(W), .NFRAC(6), .N_CLASSES(N), .IDX_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_max(out_max), .out_margin(out_margin), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int mx;
        int margin;
        int err;
        int cyc;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rmode = 0;
    int   part[$];
    exp_t exp_q[$];
    exp_t e;
    bit   holding = 0;
    bit   prev_hs = 0;
    int   h_cls, h_max, h_margin, h_err;

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Argmax by first strict maximum; second = largest of the remaining entries.
    function automatic exp_t model(input int v[$], input int last_flag);
        exp_t r;
        int   sec;
        r.cls = 0;
        r.mx  = v[0];
        for (int i = 1; i < v.size(); i++)
            if (v[i] > r.mx) begin
                r.mx  = v[i];
                r.cls = i;
            end
        sec = -4096;
        for (int i = 0; i < v.size(); i++)
            if (i != r.cls && v[i] > sec) sec = v[i];
        r.margin = r.mx - sec;
`ifdef DENSE_4_ARGMAX_SATURATE_MARGIN_EN
        if (r.margin > 4095) r.margin = 4095;
`endif
        r.err = ((last_flag != 0) != (v.size() == N)) ? 1 : 0;
        r.cyc = 0;
        return r;
    endfunction

    task automatic pin(input string name, input int v[$], input int lf,
                       input int cls, input int mx, input int mg, input int er);
        exp_t r;
        r = model(v, lf);
        chk({name, "_cls"}, r.cls, cls);
        chk({name, "_max"}, r.mx, mx);
        chk({name, "_margin"}, r.margin, mg);
        chk({name, "_err"}, r.err, er);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Compare outputs first, then track accepted beats into the model.
    always @(negedge clk) begin
        if (reset) begin
            part.delete();
            exp_q.delete();
            holding = 0;
            prev_hs = 0;
        end else begin
            if (prev_hs) chk("ready_after_handshake", in_ready, 1);
            if (out_valid) begin
                chk("ready_low_in_output", in_ready, 0);
                if (holding) begin
                    chk("hold_class", out_class, h_cls);
                    chk("hold_max", $signed(out_max), h_max);
                    chk("hold_margin", $signed(out_margin), h_margin);
                    chk("hold_err", out_err, h_err);
                end else begin
                    chk("result_pending", (exp_q.size() != 0) ? 1 : 0, 1);
                    if (exp_q.size() != 0) begin
                        chk("class", out_class, exp_q[0].cls);
                        chk("max", $signed(out_max), exp_q[0].mx);
                        chk("margin", $signed(out_margin), exp_q[0].margin);
                        chk("err", out_err, exp_q[0].err);
                        chk("latency", cyc, exp_q[0].cyc + 1);
                    end
                end
                h_cls = out_class; h_max = $signed(out_max);
                h_margin = $signed(out_margin); h_err = out_err;
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    holding = 0;
                    prev_hs = 1;
                end else begin
                    holding = 1;
                    prev_hs = 0;
                end
            end else begin
                holding = 0;
                prev_hs = 0;
            end
            if (in_valid && in_ready) begin
                part.push_back(int'($signed(in_data)));
                if (part.size() == N || in_last) begin
                    e = model(part, int'(in_last));
                    e.cyc = cyc;
                    exp_q.push_back(e);
                    part.delete();
                end
            end
        end
    end

    task automatic send_beat(input int d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d[W-1:0];
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int v[$], input bit last_at_end);
        for (int i = 0; i < v.size(); i++)
            send_beat(v[i], (i == v.size() - 1) && last_at_end);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_class"}, out_class, 0);
        chk({tag, "_out_max"}, out_max, 0);
        chk({tag, "_out_margin"}, out_margin, 0);
        chk({tag, "_out_err"}, out_err, 0);
    endtask

    initial begin
        int q[$];
        int v;
        int n;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; rmode = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_ready, 1);

        q = {-4, -5, -5, 5, 13};       pin("pin_basic", q, 1, 4, 13, 8, 0);
        q = {10, 10, 3, -2, 0};        pin("pin_tie", q, 1, 0, 10, 0, 0);
        q = {-4096, -4096, -4096, -4096, -4096}; pin("pin_allneg", q, 1, 0, -4096, 0, 0);
        q = {7, 1, 2, 3, 4};           pin("pin_stall", q, 1, 0, 7, 3, 0);
        q = {20, 30, 5};               pin("pin_early", q, 1, 1, 30, 10, 1);
        q = {0, 0, 64, 0, 0};          pin("pin_post_reset", q, 1, 2, 64, 64, 0);
`ifdef DENSE_4_ARGMAX_SATURATE_MARGIN_EN
        q = {100};                     pin("pin_one_beat", q, 1, 0, 100, 4095, 1);
`else
        q = {100};                     pin("pin_one_beat", q, 1, 0, 100, 4196, 1);
`endif

        q = {-4, -5, -5, 5, 13};       send_frame(q, 1);
        q = {10, 10, 3, -2, 0};        send_frame(q, 1);
        q = {-4096, -4096, -4096, -4096, -4096}; send_frame(q, 1);

        rmode = 2;
        q = {7, 1, 2, 3, 4};           send_frame(q, 1);
        repeat (3) @(negedge clk);
        rmode = 0;
        q = {1, 2, 3, 4, 5};           send_frame(q, 1);

        q = {20, 30, 5};               send_frame(q, 1);
        q = {-1, -2, -3, -4, -5};      send_frame(q, 1);
        q = {3, 9, 9, 1, 2};           send_frame(q, 0);
        q = {100};                     send_frame(q, 1);
        q = {4095, -4096, 4095, 0, 1}; send_frame(q, 1);

        send_beat(11, 1'b0);
        send_beat(12, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("mid_frame_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        q = {0, 0, 64, 0, 0};          send_frame(q, 1);

        rmode = 2;
        q = {50, 40, 30, 20, 10};      send_frame(q, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("mid_output_reset");
        reset = 1'b0;
        rmode = 0;
        @(posedge clk);
        #1;
        q = {6, 5, 4, 3, 2};           send_frame(q, 1);

        rmode = 1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 4)) - 2;
                1:       v = ($urandom_range(0, 1) != 0) ? 4095 : -4096;
                default: v = int'($urandom_range(0, 8191)) - 4096;
            endcase
            send_beat(v, ($urandom_range(0, 5) == 0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        send_beat(int'($urandom_range(0, 200)) - 100, 1'b1);

        rmode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dense_4_argmax_out.md
Name: dense_4_argmax_out

Overview:
- Output stage directly downstream of the dense_4 layer of the Batchnorm-JetTagging network.
- Consumes the 5 class logits that dense_4 produces (13-bit signed, 6 fractional bits), one logit per beat over a valid/ready stream.
- Emits the winning jet class index, its logit, and the top-1/top-2 margin, which serves as a confidence measure.
- Replaces softmax for the classification decision; softmax is monotonic, so the argmax is the same.

Parameters:
- W, 13, logit width in bits, two's complement.
- NFRAC, 6, fractional bits. Informational only; no rescaling is done.
- N_CLASSES, 5, logits per frame. Must be at least 2.
- IDX_W, 3, index width. Must satisfy 2^IDX_W >= N_CLASSES.

Ports:
- clk  in  1  Single clock.
- reset  in  1  Synchronous, active-high reset.
- in_valid  in  1  Logit beat valid.
- in_ready  out  1  Block can accept a beat.
- in_data  in  W  Logit, signed Q(W-NFRAC).NFRAC.
- in_last  in  1  Final beat of the frame.
- out_valid  out  1  Result valid.
- out_ready  in  1  Downstream accepts the result.
- out_class  out  IDX_W  Index of the maximum logit.
- out_max  out  W  Maximum logit value.
- out_margin  out  W+1  max minus second max, signed. Always >= 0.
- out_err  out  1  Frame-length error flag for this result.

Behaviour:
- Reset values:
  - State = ACCUM, beat index = 0.
  - in_ready = 0 during the reset cycle, then 1.
  - out_valid = 0; out_class = 0; out_max = 0; out_margin = 0; out_err = 0.
  - Running max = most-negative W-bit value (-2^(W-1)); running second = most-negative value.
- State machine:
  - ACCUM: in_ready = 1. A beat is accepted when in_valid & in_ready.
  - OUTPUT: in_ready = 0, out_valid = 1.
  - ACCUM -> OUTPUT on the cycle the frame's final beat is accepted.
  - OUTPUT -> ACCUM when out_valid & out_ready. The running registers are re-initialised in that same cycle.
- Per accepted beat at index i (signed compare):
  - If in_data > max (strictly greater): second <= max, max <= in_data, class <= i.
  - Else if in_data > second: second <= in_data.
  - Ties keep the earlier index. The lowest index wins an equal maximum.
- Frame termination: the frame ends on the accepted beat where i == N_CLASSES-1, or where in_last = 1, whichever comes first.
- out_err is registered with the result. out_err = 1 iff in_last != (i == N_CLASSES-1) on the terminating beat, covering both an early last and a missing last.
- On a missing last, the next beat starts a new frame.
- Latency: the result is valid in the cycle after the terminating beat is accepted. Throughput is N_CLASSES+1 cycles per frame with out_ready held high.
- Output hold: out_class, out_max, out_margin and out_err are all registered. They stay stable while out_valid = 1 and out_ready = 0.
- Margin arithmetic: computed at W+1 bits, sign-extended, as max - second. It cannot overflow.
  - For a one-beat (early) frame, second is the most-negative value, so margin = max + 2^(W-1).
- Reset asserted mid-frame or mid-OUTPUT: partial state is discarded and no result is emitted. All outputs return to their reset values on the next edge.

Optional Feature:
- Macro: DENSE_4_ARGMAX_SATURATE_MARGIN_EN
- Defined:
  - out_margin is clamped to the range [0, 2^(W-1)-1], i.e. a W-bit positive range; the port stays W+1 wide with the MSB = 0.
  - A one-beat frame reports the clamp value 4095 for W = 13.
- Undefined: the margin is unclamped, as described in Behaviour.

Test Plan:
- Logits -4, -5, -5, 5, 13 with in_last on beat 4 and out_ready = 1 -> one cycle later: out_valid = 1, out_class = 4, out_max = 13, out_margin = 8, out_err = 0.
- Tie, logits 10, 10, 3, -2, 0 -> out_class = 0, out_max = 10, out_margin = 0.
- All logits -4096 -> out_class = 0, out_max = -4096, out_margin = 0, out_err = 0.
- Frame 7, 1, 2, 3, 4 with out_ready held low for 3 cycles after out_valid -> in_ready = 0 and outputs stable for 3 cycles. The beat after the handshake is accepted and is the first beat of the next frame.
- in_last on beat 2 of 20, 30, 5 -> out_class = 1, out_max = 30, out_margin = 10, out_err = 1. The next frame is processed normally.
- reset asserted after beat 2 of a frame, then a full frame 0, 0, 64, 0, 0 -> no stale result; out_class = 2, out_max = 64, out_margin = 64.
